// File: rtl/serial_pkg.sv
// Shared definitions for the serial link receiver and transmitter:
// deserializer state encoding and bit-order constants.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PARITY
    } deser_state_e;

    localparam bit LSB_FIRST_C = 1'b1;
    localparam bit MSB_FIRST_C = 1'b0;

endpackage

// File: rtl/deser_out_buf.sv
// Output word buffer of the deserializer: holds dout/dout_valid, handles load, drain and overrun.
// Build option PARITY_CHECK_EN adds a parity_err flag registered alongside dout.
module deser_out_buf #(
    parameter int N_BITS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [N_BITS-1:0] word,
`ifdef PARITY_CHECK_EN
    input  logic              perr_in,
`endif
    input  logic              out_ready,
    output logic [N_BITS-1:0] dout,
    output logic              dout_valid,
`ifdef PARITY_CHECK_EN
    output logic              parity_err,
`endif
    output logic              overrun
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else if (load) begin
            // A buffer being drained on this edge counts as free.
            if (!dout_valid || out_ready) begin
                dout       <= word;
                dout_valid <= 1'b1;
                overrun    <= 1'b0;
`ifdef PARITY_CHECK_EN
                parity_err <= perr_in;
`endif
            end else begin
                overrun <= 1'b1;
            end
        end else begin
            overrun <= 1'b0;
            if (dout_valid && out_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_deser.sv
// Serial-in/parallel-out receiver with a double-buffered valid/ready output.
// Build option PARITY_CHECK_EN appends an even-parity bit to every word.
//
// state     | meaning
// ST_IDLE   | no bits held, count = 0
// ST_SHIFT  | 1..N_BITS-1 data bits held
// ST_PARITY | all data bits held, waiting for the parity bit
import serial_pkg::*;

module serial_deser #(
    parameter int N_BITS    = 8,
    parameter bit LSB_FIRST = LSB_FIRST_C
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sin,
    input  logic              sin_valid,
    input  logic              clear,
    output logic [N_BITS-1:0] dout,
    output logic              dout_valid,
    input  logic              out_ready,
    output logic              busy,
`ifdef PARITY_CHECK_EN
    output logic              parity_err,
`endif
    output logic              overrun
);

    localparam int CW = $clog2(N_BITS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N_BITS - 1);

    deser_state_e      state;
    logic [CW-1:0]     count;
    logic [N_BITS-1:0] sr;
    logic [N_BITS-1:0] sr_next;
    logic [N_BITS-1:0] word;
    logic              take;
    logic              complete;

    always_comb begin
        sr_next = LSB_FIRST ? {sin, sr[N_BITS-1:1]} : {sr[N_BITS-2:0], sin};
    end

    assign take = sin_valid && !clear;

`ifdef PARITY_CHECK_EN
    logic perr;
    assign complete = take && (state == ST_PARITY);
    assign word     = sr;
    assign perr     = ^{sr, sin};
`else
    // Last data bit goes straight into the buffer, bypassing sr.
    assign complete = take && (state == ST_SHIFT) && (count == LAST_CNT);
    assign word     = sr_next;
`endif

    assign busy = (count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
            sr    <= '0;
        end else if (clear) begin
            state <= ST_IDLE;
            count <= '0;
        end else if (sin_valid) begin
            case (state)
                ST_IDLE: begin
                    sr    <= sr_next;
                    count <= CW'(1);
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    sr <= sr_next;
                    if (count == LAST_CNT) begin
`ifdef PARITY_CHECK_EN
                        count <= count + CW'(1);
                        state <= ST_PARITY;
`else
                        count <= '0;
                        state <= ST_IDLE;
`endif
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                ST_PARITY: begin
                    count <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    count <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    deser_out_buf #(
        .N_BITS(N_BITS)
    ) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (complete),
        .word      (word),
`ifdef PARITY_CHECK_EN
        .perr_in   (perr),
`endif
        .out_ready (out_ready),
        .dout      (dout),
        .dout_valid(dout_valid),
`ifdef PARITY_CHECK_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_serial_deser.sv
// Directed bench for serial_deser: LSB-first and MSB-first instances share one stimulus stream.
module tb_serial_deser;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sin = 1'b0;
    logic       sin_valid = 1'b0;
    logic       clear = 1'b0;
    logic       out_ready = 1'b0;

    logic [7:0] l_dout, m_dout;
    logic       l_valid, m_valid, l_busy, m_busy, l_ovr, m_ovr;
`ifdef PARITY_CHECK_EN
    logic       l_perr, m_perr;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_deser #(.N_BITS(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .clear(clear),
        .dout(l_dout), .dout_valid(l_valid), .out_ready(out_ready), .busy(l_busy),
`ifdef PARITY_CHECK_EN
        .parity_err(l_perr),
`endif
        .overrun(l_ovr)
    );

    serial_deser #(.N_BITS(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .clear(clear),
        .dout(m_dout), .dout_valid(m_valid), .out_ready(out_ready), .busy(m_busy),
`ifdef PARITY_CHECK_EN
        .parity_err(m_perr),
`endif
        .overrun(m_ovr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic b);
        sin       = b;
        sin_valid = 1'b1;
        @(posedge clk);
        #1;
        sin_valid = 1'b0;
        sin       = 1'b0;
    endtask

    // Sends w LSB first; out_ready is forced to last_rdy on the completion edge only.
    task automatic send_word(input logic [7:0] w, input logic pflip, input logic last_rdy);
        logic saved;
        saved = out_ready;
        for (int i = 0; i < 8; i++) begin
`ifndef PARITY_CHECK_EN
            if (i == 7) out_ready = last_rdy;
`endif
            bit_in(w[i]);
        end
`ifdef PARITY_CHECK_EN
        out_ready = last_rdy;
        bit_in((^w) ^ pflip);
`endif
        out_ready = saved;
    endtask

    logic [7:0] pat;

    initial begin
        pat = 8'h4D;   // wire order LSB first: 1,0,1,1,0,0,1,0

        #1 reset = 1'b1;
        tick();
        tick();
        check("rst_dout",  {24'h0, l_dout}, 32'h0);
        check("rst_valid", {31'h0, l_valid}, 32'h0);
        check("rst_busy",  {31'h0, l_busy}, 32'h0);
        check("rst_ovr",   {31'h0, l_ovr}, 32'h0);
        reset = 1'b0;
        tick();

        // 1: consecutive bits, out_ready=1
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) bit_in(pat[i]);
        check("t1_busy7",  {31'h0, l_busy}, 32'h1);
        check("t1_valid7", {31'h0, l_valid}, 32'h0);
        bit_in(pat[7]);
`ifdef PARITY_CHECK_EN
        check("t1_busy_par", {31'h0, l_busy}, 32'h1);
        check("t1_valid_par", {31'h0, l_valid}, 32'h0);
        bit_in(1'b0);
`endif
        check("t1_dout",   {24'h0, l_dout}, 32'h4D);
        check("t1_valid",  {31'h0, l_valid}, 32'h1);
        check("t1_busy",   {31'h0, l_busy}, 32'h0);
        check("t1_mdout",  {24'h0, m_dout}, 32'hB2);

        // 2: same bits with 3-cycle gaps, MSB-first instance
        tick();
        check("t2_drained", {31'h0, m_valid}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            bit_in(pat[i]);
            if (i < 7) begin
                repeat (3) begin
                    tick();
                    check("t2_busy_gap", {31'h0, m_busy}, 32'h1);
                end
            end
        end
`ifdef PARITY_CHECK_EN
        repeat (3) tick();
        bit_in(1'b0);
`endif
        check("t2_mdout",  {24'h0, m_dout}, 32'hB2);
        check("t2_mvalid", {31'h0, m_valid}, 32'h1);
        check("t2_mbusy",  {31'h0, m_busy}, 32'h0);

        // 3: buffer full, second word dropped
        tick();
        check("t3_drained", {31'h0, l_valid}, 32'h0);
        out_ready = 1'b0;
        send_word(8'hA5, 1'b0, 1'b0);
        check("t3_dout1",  {24'h0, l_dout}, 32'hA5);
        check("t3_valid1", {31'h0, l_valid}, 32'h1);
        check("t3_ovr0",   {31'h0, l_ovr}, 32'h0);
        send_word(8'h3C, 1'b0, 1'b0);
        check("t3_ovr1",   {31'h0, l_ovr}, 32'h1);
        check("t3_dout2",  {24'h0, l_dout}, 32'hA5);
        check("t3_busy",   {31'h0, l_busy}, 32'h0);
        tick();
        check("t3_ovr_end", {31'h0, l_ovr}, 32'h0);
        check("t3_dout3",  {24'h0, l_dout}, 32'hA5);
        check("t3_valid3", {31'h0, l_valid}, 32'h1);

        // 4: completion coincides with drain
        send_word(8'h5A, 1'b0, 1'b1);
        check("t4_dout",   {24'h0, l_dout}, 32'h5A);
        check("t4_valid",  {31'h0, l_valid}, 32'h1);
        check("t4_ovr",    {31'h0, l_ovr}, 32'h0);
        tick();
        check("t4_valid2", {31'h0, l_valid}, 32'h1);
        check("t4_ovr2",   {31'h0, l_ovr}, 32'h0);

        // 5a: asynchronous reset mid-word
        bit_in(1'b1);
        bit_in(1'b1);
        bit_in(1'b0);
        check("t5_busy3",  {31'h0, l_busy}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("t5_rdout",  {24'h0, l_dout}, 32'h0);
        check("t5_rvalid", {31'h0, l_valid}, 32'h0);
        check("t5_rbusy",  {31'h0, l_busy}, 32'h0);
        check("t5_rmbusy", {31'h0, m_busy}, 32'h0);
        tick();
        reset = 1'b0;
        send_word(8'h96, 1'b0, 1'b0);
        check("t5_dout_rst", {24'h0, l_dout}, 32'h96);
        check("t5_valid_rst", {31'h0, l_valid}, 32'h1);

        // 5b: clear mid-word, with a sin_valid on the clear edge
        bit_in(1'b1);
        bit_in(1'b1);
        bit_in(1'b1);
        sin = 1'b1;
        sin_valid = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        sin_valid = 1'b0;
        sin = 1'b0;
        check("t5_cbusy",  {31'h0, l_busy}, 32'h0);
        check("t5_cdout",  {24'h0, l_dout}, 32'h96);
        check("t5_cvalid", {31'h0, l_valid}, 32'h1);
        out_ready = 1'b1;
        tick();
        check("t5_drain",  {31'h0, l_valid}, 32'h0);
        send_word(8'h21, 1'b0, 1'b1);
        check("t5_dout_clr", {24'h0, l_dout}, 32'h21);
        check("t5_valid_clr", {31'h0, l_valid}, 32'h1);

`ifdef PARITY_CHECK_EN
        // 6: parity flag
        send_word(8'h4D, 1'b0, 1'b1);
        check("t6_dout0",  {24'h0, l_dout}, 32'h4D);
        check("t6_perr0",  {31'h0, l_perr}, 32'h0);
        send_word(8'h4D, 1'b1, 1'b1);
        check("t6_dout1",  {24'h0, l_dout}, 32'h4D);
        check("t6_perr1",  {31'h0, l_perr}, 32'h1);
        check("t6_valid1", {31'h0, l_valid}, 32'h1);
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
